mantissa_adder: RTL and testbench
=================================

# mantissa_adder

Multi-cycle, slice-serial 25-bit mantissa adder. It is the callee of the FP add controller: it accepts two 25-bit operands over a valid/ack handshake and returns a 25-bit sum plus carry-out and a 2-bit exception code. It is area-optimised: one SLICE_W-bit adder slice is reused across 25/SLICE_W cycles, with the carry held in a register between slices.

## Interface
- SLICE_W, 5, bits added per cycle; must divide 25 (legal: 1, 5, 25); N = 25/SLICE_W slices
- CLK  input  1  clock; all state updates on posedge
- RSTn  input  1  reset, synchronous, active-low
- Adder_datain1  input  25  operand A; sampled only on acceptance
- Adder_datain2  input  25  operand B (already complemented by caller for effective subtraction); sampled only on acceptance
- Adder_valid  input  1  request; level, held high by caller until it observes ack
- Adder_dataout  output  25  sum bits [24:0]; registered; held until next completed operation
- Adder_carryout  output  1  carry out of bit 24; registered; held like dataout
- Adder_Exc  output  2  exception code; 2'b00 for every completed addition; 01/10/11 reserved (caller treats nonzero as fatal)
- Adder_ack  output  1  single-cycle completion pulse; registered

## Operation
- Function: {Adder_carryout, Adder_dataout} = Adder_datain1 + Adder_datain2, unsigned, 26-bit result, no saturation.
- Reset values: Adder_dataout 0, Adder_carryout 0, Adder_Exc 0, Adder_ack 0, state MA_Idle, slice counter 0, carry register 0, operand registers 0.
- MA_Idle: if Adder_valid=1, capture both operands, clear the carry register and slice counter, go to MA_Busy. Otherwise stay.
- MA_Busy, each cycle: add slice k of A and B with carry_reg; write the SLICE_W sum bits into the result shadow register at [k*SLICE_W +: SLICE_W]; carry_reg <= slice cout; k <= k+1.
  - After slice N-1: copy the shadow to Adder_dataout, copy cout to Adder_carryout, set Adder_Exc=00, set Adder_ack=1, go to MA_Done.
  - If Adder_valid=0 is sampled in MA_Busy: abort to MA_Idle. No ack; outputs keep their previous values; the shadow is discarded.
- MA_Done (ack high this cycle): ack clears at the next edge.
  - Adder_valid=1 sampled: go to MA_WaitRel.
  - Otherwise: go to MA_Idle.
- MA_WaitRel: stay while Adder_valid=1; go to MA_Idle on the first sample of 0. Valid held high never restarts an operation.
- Outputs change only on completion or reset; dataout/carryout are stable during and after the ack cycle.

## Timing
- Edge E0: Adder_valid first sampled high in MA_Idle (acceptance).
- Edges E1..EN: slices computed. Adder_ack is high in the cycle between EN and EN+1 (SLICE_W=5: ack 5 cycles after acceptance; total request-to-ack N+1 cycles).
- The caller samples ack at EN+1 and deasserts valid from EN+1. The adder is in MA_WaitRel at EN+1 and MA_Idle at EN+2. Earliest new acceptance: EN+3.
- Reset mid-operation: at the first edge with RSTn=0, all outputs and state take their reset values, regardless of valid.
- Valid low in MA_Idle or MA_WaitRel: no effect on outputs.

## Structure
- Shared package fpu_pkg:
  - enum mantissa_adder_state {MA_Idle, MA_Busy, MA_Done, MA_WaitRel}
  - constant MANT_W=25
  - Adder_Exc codes: ADD_EXC_NONE=2'b00, with reserved entries
- One sub-module, slice_adder: combinational SLICE_W-bit ripple adder with cin/cout, instantiated once.
- Slice counter width: $clog2(N) (minimum 1 bit).

## Test plan
- A=0x0800000, B=0x0800000, valid held until ack -> dataout 0x1000000, carry 0, Exc 00, ack single pulse 5 cycles after acceptance (SLICE_W=5).
- A=0x1FFFFFF, B=0x0000001 -> dataout 0x0000000, carry 1 (full carry ripple across all 5 slices).
- A=0x0C00000, B=0x1800000 (two's complement of 0x0800000) -> dataout 0x0400000, carry 1.
- Valid dropped after 2 MA_Busy cycles -> no ack, dataout/carryout retain the prior result; the next request A=3, B=4 returns 0x0000007.
- Valid held high 3 cycles past ack -> exactly one ack and no restart; after valid is low for one cycle, a new request is accepted and acked normally.
- RSTn low at the 3rd MA_Busy cycle -> next edge: all outputs 0, state MA_Idle; with valid still high after reset release, a fresh operation starts and completes correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: mantissa width, adder FSM states
// and adder exception codes.
package fpu_pkg;

  localparam int MANT_W = 25;

  typedef enum logic [1:0] {
    MA_Idle,
    MA_Busy,
    MA_Done,
    MA_WaitRel
  } mantissa_adder_state;

  typedef logic [1:0] add_exc_t;

  localparam add_exc_t ADD_EXC_NONE = 2'b00;
  localparam add_exc_t ADD_EXC_RSV1 = 2'b01;
  localparam add_exc_t ADD_EXC_RSV2 = 2'b10;
  localparam add_exc_t ADD_EXC_RSV3 = 2'b11;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mantissa_adder_if.sv
// Request/ack bundle between the FP add controller
// and the slice-serial mantissa adder.
interface mantissa_adder_if;
  import fpu_pkg::*;

  logic [MANT_W-1:0] Adder_datain1;
  logic [MANT_W-1:0] Adder_datain2;
  logic              Adder_valid;
  logic [MANT_W-1:0] Adder_dataout;
  logic              Adder_carryout;
  add_exc_t          Adder_Exc;
  logic              Adder_ack;

  modport master (
    output Adder_datain1,
    output Adder_datain2,
    output Adder_valid,
    input  Adder_dataout,
    input  Adder_carryout,
    input  Adder_Exc,
    input  Adder_ack
  );

  modport slave (
    input  Adder_datain1,
    input  Adder_datain2,
    input  Adder_valid,
    output Adder_dataout,
    output Adder_carryout,
    output Adder_Exc,
    output Adder_ack
  );

endinterface

// File: rtl/mantissa_adder_slice.sv
// Combinational W-bit ripple-carry adder slice,
// reused every cycle by the mantissa adder.
module slice_adder #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[W];
  end

endmodule

// File: rtl/mantissa_adder.sv
// Slice-serial 25-bit mantissa adder: one SLICE_W-bit
// slice per cycle, carry held between slices.
module mantissa_adder #(
  parameter int SLICE_W = 5
) (
  input logic             CLK,
  input logic             RSTn,
  mantissa_adder_if.slave bus
);
  import fpu_pkg::*;

  localparam int N  = MANT_W / SLICE_W;
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mantissa_adder_state state_q;
  mantissa_adder_state state_d;

  logic [MANT_W-1:0] a_q;
  logic [MANT_W-1:0] b_q;
  logic [MANT_W-1:0] shadow_q;
  logic [MANT_W-1:0] shadow_d;
  logic [MANT_W-1:0] dout_q;
  logic [CW-1:0]     k_q;
  logic              carry_q;
  logic              cout_q;
  add_exc_t          exc_q;
  logic              ack_q;

  logic              accept;
  logic              step;
  logic              finish;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;

  always_ff @(posedge CLK) begin
    if (!RSTn) state_q <= MA_Idle;
    else       state_q <= state_d;
  end

  // Valid low in Busy aborts, even on the last slice.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      MA_Idle: begin
        if (bus.Adder_valid) begin
          accept  = 1'b1;
          state_d = MA_Busy;
        end
      end
      MA_Busy: begin
        if (!bus.Adder_valid) begin
          state_d = MA_Idle;
        end else begin
          step = 1'b1;
          if (k_q == LAST) begin
            finish  = 1'b1;
            state_d = MA_Done;
          end
        end
      end
      MA_Done: begin
        state_d = bus.Adder_valid ? MA_WaitRel
                                  : MA_Idle;
      end
      MA_WaitRel: begin
        if (!bus.Adder_valid) state_d = MA_Idle;
      end
      default: state_d = MA_Idle;
    endcase
  end

  always_comb begin
    sl_a     = '0;
    sl_b     = '0;
    shadow_d = shadow_q;
    for (int i = 0; i < N; i++) begin
      if (k_q == CW'(i)) begin
        sl_a = a_q[i*SLICE_W +: SLICE_W];
        sl_b = b_q[i*SLICE_W +: SLICE_W];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (k_q == CW'(i))
        shadow_d[i*SLICE_W +: SLICE_W] = sl_sum;
    end
  end

  slice_adder #(
    .W (SLICE_W)
  ) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      exc_q    <= ADD_EXC_NONE;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= finish;
      if (accept) begin
        a_q     <= bus.Adder_datain1;
        b_q     <= bus.Adder_datain2;
        carry_q <= 1'b0;
        k_q     <= '0;
      end
      if (step) begin
        shadow_q <= shadow_d;
        carry_q  <= sl_cout;
        k_q      <= k_q + CW'(1);
      end
      if (finish) begin
        dout_q <= shadow_d;
        cout_q <= sl_cout;
        exc_q  <= ADD_EXC_NONE;
      end
    end
  end

  assign bus.Adder_dataout  = dout_q;
  assign bus.Adder_carryout = cout_q;
  assign bus.Adder_Exc      = exc_q;
  assign bus.Adder_ack      = ack_q;

endmodule

// File: tb/tb_mantissa_adder.sv
// Directed scoreboard bench for mantissa_adder
// (SLICE_W=5, request-to-ack six edges).
module tb_mantissa_adder;
  import fpu_pkg::*;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  always #5 CLK = ~CLK;

  mantissa_adder_if bif ();

  mantissa_adder #(
    .SLICE_W (5)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bif)
  );

  int tests = 0;
  int fails = 0;
  logic [25:0] exp_q [$];
  logic [25:0] last = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic start(input logic [24:0] a,
                       input logic [24:0] b,
                       input bit push);
    @(negedge CLK);
    bif.Adder_datain1 = a;
    bif.Adder_datain2 = b;
    bif.Adder_valid   = 1'b1;
    if (push)
      exp_q.push_back({1'b0, a} + {1'b0, b});
  endtask

  task automatic wait_ack(input string tag,
                          input int lat);
    int n = 0;
    bit seen = 1'b0;
    logic [25:0] e;
    while (!seen && n < 20) begin
      cyc();
      n++;
      seen = bif.Adder_ack;
    end
    chk({tag, "_ack"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_lat"}, 32'(n), 32'(lat));
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_data"},
            32'(bif.Adder_dataout), 32'(e[24:0]));
        chk({tag, "_carry"},
            32'(bif.Adder_carryout), 32'(e[25]));
        chk({tag, "_exc"},
            32'(bif.Adder_Exc), 32'(ADD_EXC_NONE));
        last = e;
      end
    end
  endtask

  task automatic release_chk(input string tag);
    bif.Adder_valid = 1'b0;
    cyc();
    chk({tag, "_ack_pulse"},
        32'(bif.Adder_ack), 32'd0);
    chk({tag, "_hold_data"},
        32'(bif.Adder_dataout), 32'(last[24:0]));
    chk({tag, "_hold_carry"},
        32'(bif.Adder_carryout), 32'(last[25]));
  endtask

  initial begin
    bif.Adder_datain1 = '0;
    bif.Adder_datain2 = '0;
    bif.Adder_valid   = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_data", 32'(bif.Adder_dataout), 32'd0);
    chk("rst_carry", 32'(bif.Adder_carryout), 32'd0);
    chk("rst_exc", 32'(bif.Adder_Exc), 32'd0);
    chk("rst_ack", 32'(bif.Adder_ack), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(MA_Idle));
    RSTn = 1'b1;

    start(25'h0800000, 25'h0800000, 1'b1);
    wait_ack("t1", 6);
    release_chk("t1");

    start(25'h1FFFFFF, 25'h0000001, 1'b1);
    wait_ack("t2", 6);
    release_chk("t2");

    start(25'h0C00000, 25'h1800000, 1'b1);
    wait_ack("t3", 6);
    release_chk("t3");

    // Abort after two busy cycles.
    start(25'h1234567, 25'h0ABCDEF, 1'b0);
    repeat (3) begin
      cyc();
      chk("t4_no_ack", 32'(bif.Adder_ack), 32'd0);
    end
    bif.Adder_valid = 1'b0;
    repeat (3) begin
      cyc();
      chk("t4_no_ack2", 32'(bif.Adder_ack), 32'd0);
      chk("t4_keep", 32'(bif.Adder_dataout),
          32'(last[24:0]));
      chk("t4_keepc", 32'(bif.Adder_carryout),
          32'(last[25]));
    end
    chk("t4_state", 32'(dut.state_q), 32'(MA_Idle));
    start(25'd3, 25'd4, 1'b1);
    wait_ack("t4b", 6);
    release_chk("t4b");

    // Valid held three cycles past ack.
    start(25'h0155555, 25'h0AAAAAA, 1'b1);
    wait_ack("t5", 6);
    repeat (3) begin
      cyc();
      chk("t5_one_ack", 32'(bif.Adder_ack), 32'd0);
      chk("t5_wait", 32'(dut.state_q),
          32'(MA_WaitRel));
      chk("t5_stable", 32'(bif.Adder_dataout),
          32'(last[24:0]));
    end
    bif.Adder_valid = 1'b0;
    cyc();
    chk("t5_idle", 32'(dut.state_q), 32'(MA_Idle));
    start(25'h1000000, 25'h1000000, 1'b1);
    wait_ack("t5b", 6);
    release_chk("t5b");

    // Reset on the third busy edge.
    start(25'h00F0F0F, 25'h0101010, 1'b1);
    repeat (3) cyc();
    RSTn = 1'b0;
    cyc();
    chk("t6_data", 32'(bif.Adder_dataout), 32'd0);
    chk("t6_carry", 32'(bif.Adder_carryout), 32'd0);
    chk("t6_exc", 32'(bif.Adder_Exc), 32'd0);
    chk("t6_ack", 32'(bif.Adder_ack), 32'd0);
    chk("t6_state", 32'(dut.state_q), 32'(MA_Idle));
    RSTn = 1'b1;
    wait_ack("t6", 6);
    release_chk("t6");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
